// File: rtl/mole_game_ctrl.sv
// Whac-A-Mole game sequencer: drives the timer state code, spawns one LFSR-chosen
// mole at a time and keeps a saturating two-digit BCD score.
module mole_game_ctrl #(
  parameter int          MOLE_LIFE = 50_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_conf,
  input  logic [7:0] hit,
  input  logic       timeover,
  output logic [4:0] state,
  output logic [7:0] mole,
  output logic [7:0] score
);

  localparam logic [4:0] ST_IDLE  = 5'd0;
  localparam logic [4:0] ST_SET   = 5'd1;
  localparam logic [4:0] ST_READY = 5'd2;
  localparam logic [4:0] ST_PLAY  = 5'd3;
  localparam logic [4:0] ST_OVER  = 5'd4;

  localparam int                LIFE_W    = (MOLE_LIFE > 2) ? $clog2(MOLE_LIFE) : 1;
  localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(MOLE_LIFE - 1);

  logic [4:0]        r_state;
  logic [4:0]        w_next_state;
  logic [7:0]        r_mole;
  logic [7:0]        r_score;
  logic [7:0]        w_score_inc;
  logic [7:0]        w_new_mole;
  logic [15:0]       r_lfsr;
  logic              w_lfsr_fb;
  logic [LIFE_W-1:0] r_life;
  logic              r_spawn;
  logic [2:0]        w_cand;
  logic [2:0]        w_pos;
  logic              w_hit;
  logic              w_expire;
  logic              w_enter_set;

  assign state = r_state;
  assign mole  = r_mole;
  assign score = r_score;

  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // Skip to the next position when the candidate is already lit, so an
  // expiring mole never reappears in the same hole.
  assign w_cand      = r_lfsr[2:0];
  assign w_pos       = r_mole[w_cand] ? (w_cand + 3'd1) : w_cand;
  assign w_new_mole  = 8'd1 << w_pos;
  assign w_hit       = (r_state == ST_PLAY) && ((hit & r_mole) != 8'd0);
  assign w_expire    = (r_life == LIFE_LAST);
  assign w_enter_set = (w_next_state == ST_SET) && (r_state != ST_SET);

  always_comb begin
    w_score_inc = r_score;
    if (r_score == 8'h99) begin
      w_score_inc = r_score;
    end else if (r_score[3:0] == 4'd9) begin
      w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
    end else begin
      w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next_state = btn_start ? ST_SET : ST_IDLE;
      ST_SET:   w_next_state = btn_conf ? ST_READY : ST_SET;
      ST_READY: w_next_state = timeover ? ST_OVER : ST_PLAY;
      ST_PLAY:  w_next_state = timeover ? ST_OVER : ST_PLAY;
      ST_OVER:  w_next_state = btn_start ? ST_SET : ST_OVER;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_score <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
      if (w_enter_set) begin
        r_score <= 8'h00;
      end else if (w_hit) begin
        r_score <= w_score_inc;
      end
    end
  end

  // r_spawn marks a blank PLAY cycle whose end lights a fresh mole: the first
  // PLAY cycle and the cycle after every hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mole  <= 8'h00;
      r_life  <= '0;
      r_spawn <= 1'b0;
    end else if (r_state == ST_PLAY) begin
      if (timeover) begin
        r_mole  <= 8'h00;
        r_life  <= '0;
        r_spawn <= 1'b0;
      end else if (w_hit) begin
        r_mole  <= 8'h00;
        r_life  <= '0;
        r_spawn <= 1'b1;
      end else if (r_spawn || w_expire) begin
        r_mole  <= w_new_mole;
        r_life  <= '0;
        r_spawn <= 1'b0;
      end else begin
        r_life  <= r_life + LIFE_W'(1);
      end
    end else begin
      r_mole  <= 8'h00;
      r_life  <= '0;
      r_spawn <= (r_state == ST_READY) && !timeover;
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with MOLE_LIFE=8; a reference LFSR predicts
// every spawned mole position.
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_conf = 1'b0;
  logic [7:0] hit = 8'h00;
  logic       timeover = 1'b0;
  logic [4:0] state;
  logic [7:0] mole;
  logic [7:0] score;

  int total = 0;
  int bad = 0;
  int nScore = 0;
  logic [15:0] m_lfsr;

  mole_game_ctrl #(.MOLE_LIFE(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_conf(btn_conf),
    .hit(hit), .timeover(timeover), .state(state), .mole(mole), .score(score)
  );

  always #5 clk = ~clk;

  // Reference Fibonacci LFSR, taps 16,14,13,11, shifting every cycle from the seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [7:0] bcd(input int n);
    bcd = {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] predictMole(input logic [2:0] cand, input logic [7:0] cur);
    logic [2:0] p;
    p = cur[cand] ? cand + 3'd1 : cand;
    predictMole = 8'd1 << p;
  endfunction

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    total++; if (state !== 5'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL reset_mole: got %h want 00", mole); end
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL reset_score: got %h want 00", score); end
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_sequence;
    logic [2:0] cand;
    step;
    total++; if (state !== 5'd0) begin bad++; $display("[TB] FAIL seq_idle: got %0d want 0", state); end
    btn_start = 1'b1; step; btn_start = 1'b0;
    total++; if (state !== 5'd1) begin bad++; $display("[TB] FAIL seq_set: got %0d want 1", state); end
    btn_conf = 1'b1; step; btn_conf = 1'b0;
    total++; if (state !== 5'd2) begin bad++; $display("[TB] FAIL seq_ready: got %0d want 2", state); end
    step;
    total++; if (state !== 5'd3) begin bad++; $display("[TB] FAIL seq_play: got %0d want 3", state); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL seq_first_blank: got %h want 00", mole); end
    cand = m_lfsr[2:0];
    step;
    total++; if (mole !== (8'd1 << cand)) begin bad++; $display("[TB] FAIL seq_first_mole: got %h want %h", mole, 8'd1 << cand); end
    timeover = 1'b1; step; timeover = 1'b0;
    total++; if (state !== 5'd4) begin bad++; $display("[TB] FAIL seq_over: got %0d want 4", state); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL seq_over_mole: got %h want 00", mole); end
  endtask

  task automatic test_ready_over;
    btn_start = 1'b1; step; btn_start = 1'b0;
    total++; if (state !== 5'd1) begin bad++; $display("[TB] FAIL ro_set: got %0d want 1", state); end
    btn_conf = 1'b1; timeover = 1'b1; step; btn_conf = 1'b0;
    total++; if (state !== 5'd2) begin bad++; $display("[TB] FAIL ro_ready: got %0d want 2", state); end
    step; timeover = 1'b0;
    total++; if (state !== 5'd4) begin bad++; $display("[TB] FAIL ro_over: got %0d want 4", state); end
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL ro_score: got %h want 00", score); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL ro_mole: got %h want 00", mole); end
  endtask

  task automatic test_hits;
    logic [7:0] m;
    btn_start = 1'b1; step; btn_start = 1'b0;
    btn_conf = 1'b1; step; btn_conf = 1'b0;
    step; step;
    m = mole;
    hit = ~m; step; hit = 8'h00;
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL hit_unlit: got %h want 00", score); end
    btn_start = 1'b1; btn_conf = 1'b1; step; btn_start = 1'b0; btn_conf = 1'b0;
    total++; if (state !== 5'd3) begin bad++; $display("[TB] FAIL play_ignores_buttons: got %0d want 3", state); end
    for (int i = 1; i <= 10; i++) begin
      m = mole;
      total++; if ($onehot(m) !== 1'b1) begin bad++; $display("[TB] FAIL hit_lit_%0d: got %h want one-hot", i, m); end
      hit = m; step;
      hit = (i == 1) ? 8'hFF : 8'h00;
      total++; if (score !== bcd(i)) begin bad++; $display("[TB] FAIL hit_score_%0d: got %h want %h", i, score, bcd(i)); end
      total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL hit_blank_%0d: got %h want 00", i, mole); end
      step; hit = 8'h00;
      total++; if (score !== bcd(i)) begin bad++; $display("[TB] FAIL hit_hold_%0d: got %h want %h", i, score, bcd(i)); end
    end
    nScore = 10;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 89; i++) begin
      hit = mole; step; hit = 8'h00; step;
    end
    nScore = 99;
    total++; if (score !== bcd(nScore)) begin bad++; $display("[TB] FAIL sat_reach: got %h want %h", score, bcd(nScore)); end
    hit = mole; step; hit = 8'h00;
    total++; if (score !== 8'h99) begin bad++; $display("[TB] FAIL sat_hold: got %h want 99", score); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL sat_blank: got %h want 00", mole); end
    step;
  endtask

  task automatic test_expiry;
    logic [7:0] cur;
    logic [7:0] exp;
    cur = mole;
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k < 8; k++) begin
        step;
        total++; if (mole !== cur) begin bad++; $display("[TB] FAIL exp_hold_%0d_%0d: got %h want %h", r, k, mole, cur); end
      end
      exp = predictMole(m_lfsr[2:0], cur);
      step;
      total++; if (mole !== exp) begin bad++; $display("[TB] FAIL exp_respawn_%0d: got %h want %h", r, mole, exp); end
      total++; if (mole === cur) begin bad++; $display("[TB] FAIL exp_repeat_%0d: got %h want not %h", r, mole, cur); end
      cur = exp;
    end
    total++; if (score !== 8'h99) begin bad++; $display("[TB] FAIL exp_score: got %h want 99", score); end
  endtask

  task automatic test_hit_timeover;
    timeover = 1'b1; step; timeover = 1'b0;
    total++; if (state !== 5'd4) begin bad++; $display("[TB] FAIL ht_over: got %0d want 4", state); end
    btn_start = 1'b1; step; btn_start = 1'b0;
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL ht_clear: got %h want 00", score); end
    btn_conf = 1'b1; step; btn_conf = 1'b0;
    step; step;
    nScore = 0;
    for (int i = 0; i < 42; i++) begin
      hit = mole; step; hit = 8'h00; step;
      nScore++;
    end
    total++; if (score !== 8'h42) begin bad++; $display("[TB] FAIL ht_42: got %h want 42", score); end
    hit = mole; timeover = 1'b1; step; hit = 8'h00; timeover = 1'b0;
    total++; if (score !== 8'h43) begin bad++; $display("[TB] FAIL ht_score: got %h want 43", score); end
    total++; if (state !== 5'd4) begin bad++; $display("[TB] FAIL ht_state: got %0d want 4", state); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL ht_mole: got %h want 00", mole); end
    btn_start = 1'b1; step; btn_start = 1'b0;
    total++; if (state !== 5'd1) begin bad++; $display("[TB] FAIL ht_restart: got %0d want 1", state); end
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL ht_restart_score: got %h want 00", score); end
  endtask

  task automatic test_reset_midgame;
    logic [2:0] cand;
    btn_conf = 1'b1; step; btn_conf = 1'b0;
    step; step;
    for (int i = 0; i < 3; i++) begin
      hit = mole; step; hit = 8'h00; step;
    end
    total++; if (score !== 8'h03) begin bad++; $display("[TB] FAIL mr_pre: got %h want 03", score); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (state !== 5'd0) begin bad++; $display("[TB] FAIL mr_state: got %0d want 0", state); end
    total++; if (mole !== 8'h00) begin bad++; $display("[TB] FAIL mr_mole: got %h want 00", mole); end
    total++; if (score !== 8'h00) begin bad++; $display("[TB] FAIL mr_score: got %h want 00", score); end
    step; rst_n = 1'b1;
    btn_start = 1'b1; step; btn_start = 1'b0;
    btn_conf = 1'b1; step; btn_conf = 1'b0;
    step;
    cand = m_lfsr[2:0];
    step;
    total++; if (mole !== (8'd1 << cand)) begin bad++; $display("[TB] FAIL mr_seed_mole: got %h want %h", mole, 8'd1 << cand); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_sequence;
    test_ready_over;
    test_hits;
    test_saturate;
    test_expiry;
    test_hit_timeover;
    test_reset_midgame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
